fetch_pipe_ctrl: RTL and testbench

- Consumer of the hazard unit's stall/flush/mux outputs and of the EX-stage redirect (branch taken, jal, jalr).
- Owns the PC register, drives the I-cache read request, and owns the IF/ID pipeline register and the ID/EX bubble bit.
- Buffers a redirect that arrives while the pipeline is frozen by a cache stall, so that no redirect is lost.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_redirect_buf.sv | 44 ++++
 rtl/fetch_pipe_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_pipe_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and byte-swap helper for the fetch stage
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FROZEN,
        ST_FROZEN_REDIR
    } fetch_state_e;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// rtl/fetch_redirect_buf.sv - holds the latest redirect seen while the pipeline is frozen
module fetch_redirect_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        pend_valid,
    output logic [31:0] pend_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pend_pc_q, pend_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pend_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Any advance cycle consumes (or supersedes) the pending target, so RUN is unconditional there.
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        if (!mem_stall) begin
            state_d = ST_RUN;
        end else if (redirect_en) begin
            state_d   = ST_FROZEN_REDIR;
            pend_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (state_q == ST_RUN) begin
            state_d = ST_FROZEN;
        end
    end

    assign pend_valid = (state_q == ST_FROZEN_REDIR);
    assign pend_pc    = pend_pc_q;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// rtl/fetch_pipe_ctrl.sv - PC register, I-cache request, IF/ID register and ID/EX bubble control
module fetch_pipe_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INST  = FETCH_NOP_INST,
    parameter bit          INST_SWAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        hazard_flush,
    input  logic        hazard_mux,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        mem_stall,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    output logic [31:0] pc_if,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid,
    output logic        ID_EX_bubble
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        id_ex_bubble_q, id_ex_bubble_d;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic [31:0] fetched_inst;

    fetch_redirect_buf u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .mem_stall   (mem_stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .pend_valid  (pend_valid),
        .pend_pc     (pend_pc)
    );

    assign fetched_inst = INST_SWAP ? byte_swap(ICACHE_rdata) : ICACHE_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            if_id_pc_q     <= 32'h0;
            if_id_inst_q   <= NOP_INST;
            if_id_valid_q  <= 1'b0;
            id_ex_bubble_q <= 1'b1;
        end else begin
            pc_q           <= pc_d;
            if_id_pc_q     <= if_id_pc_d;
            if_id_inst_q   <= if_id_inst_d;
            if_id_valid_q  <= if_id_valid_d;
            id_ex_bubble_q <= id_ex_bubble_d;
        end
    end

    // A live EX redirect is younger than any buffered one, so it wins even over the pending target.
    always_comb begin
        pc_d           = pc_q;
        if_id_pc_d     = if_id_pc_q;
        if_id_inst_d   = if_id_inst_q;
        if_id_valid_d  = if_id_valid_q;
        id_ex_bubble_d = id_ex_bubble_q;
        if (!mem_stall) begin
            id_ex_bubble_d = hazard_mux;
            if (redirect_en) begin
                pc_d          = {redirect_pc[31:2], 2'b00};
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
            end else if (pend_valid) begin
                pc_d          = pend_pc;
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
            end else if (hazard_stall) begin
                pc_d = pc_q;
            end else if (hazard_flush) begin
                pc_d          = pc_q + 32'd4;
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
            end else begin
                pc_d          = pc_q + 32'd4;
                if_id_pc_d    = pc_q;
                if_id_inst_d  = fetched_inst;
                if_id_valid_d = 1'b1;
            end
        end
    end

    assign ICACHE_ren   = ~rst;
    assign ICACHE_addr  = pc_q[31:2];
    assign pc_if        = pc_q;
    assign IF_ID_pc     = if_id_pc_q;
    assign IF_ID_inst   = if_id_inst_q;
    assign IF_ID_valid  = if_id_valid_q;
    assign ID_EX_bubble = id_ex_bubble_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// tb/tb_fetch_pipe_ctrl.sv - directed and randomized checks of fetch_pipe_ctrl against a behavioural model
module tb_fetch_pipe_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_stall, hazard_flush, hazard_mux;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        mem_stall;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic [31:0] pc_if, IF_ID_pc, IF_ID_inst;
    logic        IF_ID_valid, ID_EX_bubble;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_ifid_pc, m_inst;
    logic        m_valid, m_bubble;
    logic [31:0] m_pend[$];

    always #5 clk = ~clk;

    fetch_pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .hazard_stall (hazard_stall),
        .hazard_flush (hazard_flush),
        .hazard_mux   (hazard_mux),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .mem_stall    (mem_stall),
        .ICACHE_ren   (ICACHE_ren),
        .ICACHE_addr  (ICACHE_addr),
        .ICACHE_rdata (ICACHE_rdata),
        .pc_if        (pc_if),
        .IF_ID_pc     (IF_ID_pc),
        .IF_ID_inst   (IF_ID_inst),
        .IF_ID_valid  (IF_ID_valid),
        .ID_EX_bubble (ID_EX_bubble)
    );

    function automatic logic [31:0] swap_bytes(input logic [31:0] x);
        return {<<8{x}};
    endfunction

    // Drives one cycle of inputs, advances the reference model with the same inputs, samples after the edge.
    task automatic cycle(input logic r, input logic hs, input logic hf, input logic hm,
                         input logic re, input logic [31:0] rpc, input logic ms,
                         input logic [31:0] rd);
        rst = r; hazard_stall = hs; hazard_flush = hf; hazard_mux = hm;
        redirect_en = re; redirect_pc = rpc; mem_stall = ms; ICACHE_rdata = rd;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_ifid_pc = 32'h0; m_inst = NOP; m_valid = 1'b0; m_bubble = 1'b1;
            m_pend.delete();
        end else if (ms) begin
            if (re) m_pend.push_back(rpc & ~32'd3);
        end else begin
            m_bubble = hm;
            if (re) begin
                m_pc = rpc & ~32'd3; m_inst = NOP; m_valid = 1'b0;
            end else if (m_pend.size() > 0) begin
                m_pc = m_pend[$]; m_inst = NOP; m_valid = 1'b0;
            end else if (hs) begin
                m_pc = m_pc;
            end else if (hf) begin
                m_pc = m_pc + 4; m_inst = NOP; m_valid = 1'b0;
            end else begin
                m_ifid_pc = m_pc; m_inst = swap_bytes(rd); m_valid = 1'b1; m_pc = m_pc + 4;
            end
            m_pend.delete();
        end
        #1;
    endtask

    task automatic free_cycle(input logic [31:0] rd);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, rd);
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc_if !== 32'h0 || IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP || ID_EX_bubble !== 1'b1 || ICACHE_ren !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h valid=%b inst=%h bubble=%b ren=%b, want 0 0 %h 1 0", pc_if, IF_ID_valid, IF_ID_inst, ID_EX_bubble, ICACHE_ren, NOP);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ICACHE_addr !== 30'(k)) begin
                errors++;
                $display("FAIL seq_addr[%0d]: got %h want %h", k, ICACHE_addr, k);
            end
            free_cycle(32'h1300_0000);
            checks++;
            if (IF_ID_inst !== NOP || IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'(4 * k) || ID_EX_bubble !== 1'b0 || ICACHE_ren !== 1'b1) begin
                errors++;
                $display("FAIL seq_ifid[%0d]: inst=%h valid=%b pc=%h bubble=%b ren=%b, want %h 1 %h 0 1", k, IF_ID_inst, IF_ID_valid, IF_ID_pc, ID_EX_bubble, ICACHE_ren, NOP, 4 * k);
            end
        end
    endtask

    task automatic test_hazard;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        checks++;
        if (pc_if !== 32'h10 || IF_ID_pc !== 32'hC || IF_ID_valid !== 1'b1 || ID_EX_bubble !== 1'b1) begin
            errors++;
            $display("FAIL hazard_stall: pc=%h ifid_pc=%h valid=%b bubble=%b, want 10 c 1 1", pc_if, IF_ID_pc, IF_ID_valid, ID_EX_bubble);
        end
        free_cycle(32'h9300_1000);
        checks++;
        if (pc_if !== 32'h14 || ID_EX_bubble !== 1'b0 || IF_ID_inst !== 32'h0010_0093 || IF_ID_pc !== 32'h10) begin
            errors++;
            $display("FAIL hazard_release: pc=%h bubble=%b inst=%h ifid_pc=%h, want 14 0 00100093 10", pc_if, ID_EX_bubble, IF_ID_inst, IF_ID_pc);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1111_2222);
        checks++;
        if (pc_if !== 32'h18 || IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP) begin
            errors++;
            $display("FAIL hazard_flush: pc=%h valid=%b inst=%h, want 18 0 %h", pc_if, IF_ID_valid, IF_ID_inst, NOP);
        end
    endtask

    task automatic test_redirect;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h5555_5555);
        checks++;
        if (pc_if !== 32'h100 || IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP) begin
            errors++;
            $display("FAIL redirect: pc=%h valid=%b inst=%h, want 100 0 %h", pc_if, IF_ID_valid, IF_ID_inst, NOP);
        end
        free_cycle(32'h7856_3412);
        checks++;
        if (IF_ID_pc !== 32'h100 || IF_ID_valid !== 1'b1 || IF_ID_inst !== 32'h1234_5678 || pc_if !== 32'h104) begin
            errors++;
            $display("FAIL redirect_target: ifid_pc=%h valid=%b inst=%h pc=%h, want 100 1 12345678 104", IF_ID_pc, IF_ID_valid, IF_ID_inst, pc_if);
        end
    endtask

    task automatic test_freeze_redirect;
        logic [31:0] pc0;
        pc0 = pc_if;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, (k == 1), 32'h200, 1'b1, 32'hAAAA_0000);
            checks++;
            if (pc_if !== pc0 || IF_ID_pc !== 32'h100 || IF_ID_valid !== 1'b1) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: pc=%h ifid_pc=%h valid=%b, want %h 100 1", k, pc_if, IF_ID_pc, IF_ID_valid, pc0);
            end
        end
        free_cycle(32'hAAAA_0000);
        checks++;
        if (pc_if !== 32'h200 || IF_ID_inst !== NOP || IF_ID_valid !== 1'b0) begin
            errors++;
            $display("FAIL freeze_release: pc=%h inst=%h valid=%b, want 200 %h 0", pc_if, IF_ID_inst, IF_ID_valid, NOP);
        end
    endtask

    task automatic test_double_redirect;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h402, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc_if !== 32'h400) begin
            errors++;
            $display("FAIL latest_pending: pc=%h want 400", pc_if);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        checks++;
        if (pc_if !== 32'h500) begin
            errors++;
            $display("FAIL live_over_pending: pc=%h want 500", pc_if);
        end
        free_cycle(32'h0);
        checks++;
        if (pc_if !== 32'h504) begin
            errors++;
            $display("FAIL pending_cleared: pc=%h want 504", pc_if);
        end
    endtask

    task automatic test_wrap;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        checks++;
        if (pc_if !== 32'hFFFF_FFFC || ICACHE_addr !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_target: pc=%h addr=%h want fffffffc 3fffffff", pc_if, ICACHE_addr);
        end
        free_cycle(32'h1300_0000);
        checks++;
        if (pc_if !== 32'h0 || IF_ID_pc !== 32'hFFFF_FFFC || IF_ID_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: pc=%h ifid_pc=%h valid=%b want 0 fffffffc 1", pc_if, IF_ID_pc, IF_ID_valid);
        end
    endtask

    task automatic test_reset_in_freeze;
        free_cycle(32'h0);
        free_cycle(32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h700, 1'b1, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        checks++;
        if (pc_if !== 32'h0 || ID_EX_bubble !== 1'b1 || IF_ID_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_frozen: pc=%h bubble=%b valid=%b want 0 1 0", pc_if, ID_EX_bubble, IF_ID_valid);
        end
        free_cycle(32'h0);
        checks++;
        if (pc_if !== 32'h4 || IF_ID_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard_pending: pc=%h valid=%b want 4 1", pc_if, IF_ID_valid);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom,
                  ($urandom_range(0, 2) == 0), $urandom);
            checks++;
            if (pc_if !== m_pc || ICACHE_addr !== m_pc[31:2] || ICACHE_ren !== ~rst ||
                IF_ID_pc !== m_ifid_pc || IF_ID_inst !== m_inst || IF_ID_valid !== m_valid ||
                ID_EX_bubble !== m_bubble) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h ifid_pc=%h inst=%h valid=%b bubble=%b, want %h %h %h %b %b",
                         i, pc_if, IF_ID_pc, IF_ID_inst, IF_ID_valid, ID_EX_bubble,
                         m_pc, m_ifid_pc, m_inst, m_valid, m_bubble);
            end
        end
    endtask

    initial begin
        rst = 1'b1; hazard_stall = 1'b0; hazard_flush = 1'b0; hazard_mux = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'h0; mem_stall = 1'b0; ICACHE_rdata = 32'h0;
        m_pc = 32'h0; m_ifid_pc = 32'h0; m_inst = NOP; m_valid = 1'b0; m_bubble = 1'b1;
        #1;
        test_reset;
        test_hazard;
        test_redirect;
        test_freeze_redirect;
        test_double_redirect;
        test_wrap;
        test_reset_in_freeze;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
